// File: rtl/branch_cond_unit.sv
// Branch condition unit: holds architectural NZCV and resolves B / B.cond / CBZ / CBNZ in EX.
// Define BRANCH_COND_BYPASS_EN to let a B.cond use the ALU flags produced in the same cycle.
module branch_cond_unit #(
    parameter int         COND_W    = 4,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              set_flags,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              br_valid,
    input  logic [1:0]        br_type,
    input  logic [COND_W-1:0] br_cond,
    input  logic              opnd_zero,
    output logic              br_ready,
    output logic              take_valid,
    output logic              take_branch,
    output logic [3:0]        flags_q
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [1:0] BR_B    = 2'b00;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [1:0] BR_CBZ  = 2'b10;

    state_t     state, state_nxt;
    logic       hazard;
    logic       accept;
    logic [3:0] eval_flags;
    logic       taken;
    logic       vld_p1;
    logic       take_p1;

    function automatic logic cond_pass(input logic [COND_W-1:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c & !z;
            4'b1001: cond_pass = !(c & !z);
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z & (n == v);
            4'b1101: cond_pass = !(!z & (n == v));
            default: cond_pass = 1'b1;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [1:0] typ, input logic [COND_W-1:0] cond,
                                          input logic oz, input logic [3:0] f);
        case (typ)
            BR_B:    branch_taken = 1'b1;
            BR_COND: branch_taken = cond_pass(cond, f);
            BR_CBZ:  branch_taken = oz;
            default: branch_taken = !oz;
        endcase
    endfunction

`ifdef BRANCH_COND_BYPASS_EN
    assign hazard     = 1'b0;
    assign eval_flags = set_flags ? {alu_n, alu_z, alu_c, alu_v} : flags_q;
`else
    // A B.cond behind a flag-setting op must see the flags once they are architectural.
    assign hazard     = br_valid & (br_type == BR_COND) & set_flags;
    assign eval_flags = flags_q;
`endif

    assign taken    = branch_taken(br_type, br_cond, opnd_zero, eval_flags);
    assign br_ready = (state == WAIT) | !hazard;
    assign accept   = br_valid & br_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hazard) state_nxt = WAIT;
            WAIT:    if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            flags_q <= FLAGS_RST;
        end else begin
            state <= state_nxt;
            if (set_flags) flags_q <= {alu_n, alu_z, alu_c, alu_v};
        end
    end

    // Decision stage: registered take/not-take, held between valid pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            take_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept & !flush;
            if (accept & !flush) take_p1 <= taken;
        end
    end

    assign take_valid  = vld_p1;
    assign take_branch = take_p1;

endmodule
